// File: rtl/vga_sync.sv
// ----------------------------------------------------------------------------
// vga_sync -- 640x480 VGA timing generator with a 160x120 pixel-buffer
// address generator (each buffer pixel covers a 4x4 block of screen pixels).
//
// Line layout : front porch, sync, back porch, then the active pixels.
// Frame layout: front porch, sync, back porch, then the active lines.
//
// Ports
//   clk_25      in   25 MHz pixel clock (only clock)
//   reset_n     in   asynchronous active-low reset
//   h_count     out  [9:0]  horizontal position
//   v_count     out  [9:0]  vertical position
//   hsync       out  active-low horizontal sync
//   vsync       out  active-low vertical sync
//   bright      out  high inside the active 640x480 area
//   read        out  pixel-buffer read strobe, leads bright by one clock
//   addr        out  [14:0] pixel-buffer address, holds while read=0
//   frame_start out  one-clock pulse when the counters wrap to (0,0)
//
// Build option
//   VGA_SYNC_DELAY_EN  adds one register stage to hsync, vsync and bright so
//                      they line up with a downstream registered rgb stage.
// ----------------------------------------------------------------------------
module vga_sync #(
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_TOTAL = 800,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 29,
  parameter int V_TOTAL = 521
) (
  input  logic        clk_25,
  input  logic        reset_n,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        bright,
  output logic        read,
  output logic [14:0] addr,
  output logic        frame_start
);

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_SYNC_BEG = 10'(H_FP);
  localparam logic [9:0]  H_SYNC_END = 10'(H_FP + H_SYNC);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_FP);
  localparam logic [9:0]  V_SYNC_END = 10'(V_FP + V_SYNC);
  localparam logic [9:0]  H_ACT      = 10'(H_FP + H_SYNC + H_BP);
  localparam logic [9:0]  V_ACT      = 10'(V_FP + V_SYNC + V_BP);
  // read runs one clock ahead of bright and stops one clock before line end
  localparam logic [9:0]  H_RD_BEG   = 10'(H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  H_RD_END   = 10'(H_TOTAL - 2);
  localparam logic [14:0] COLS       = 15'((H_TOTAL - (H_FP + H_SYNC + H_BP)) / 4);

  logic        h_wrap, v_wrap;
  logic [9:0]  h_next, v_next;
  logic        hsync_next, vsync_next, bright_next, read_next, first_read;
  logic        hsync_r, vsync_r, bright_r;
  logic [1:0]  col_sub;   // screen pixels already read for the current buffer column
  logic [1:0]  row_sub;   // screen lines already spent on the current buffer row
  logic [14:0] row_base;  // buffer address of column 0 of the current row

  // All outputs are registered from the next counter values so they stay
  // aligned with the h_count/v_count presented in the same cycle.
  always_comb begin
    h_wrap      = (h_count == H_LAST);
    v_wrap      = (v_count == V_LAST);
    h_next      = h_wrap ? 10'd0 : h_count + 10'd1;
    v_next      = v_count;
    if (h_wrap)
      v_next = v_wrap ? 10'd0 : v_count + 10'd1;
    hsync_next  = !((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END));
    vsync_next  = !((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END));
    bright_next = (h_next >= H_ACT) && (v_next >= V_ACT);
    read_next   = (v_next >= V_ACT) && (h_next >= H_RD_BEG) && (h_next <= H_RD_END);
    first_read  = (h_next == H_RD_BEG);
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      h_count     <= 10'd0;
      v_count     <= 10'd0;
      hsync_r     <= 1'b1;
      vsync_r     <= 1'b1;
      bright_r    <= 1'b0;
      read        <= 1'b0;
      addr        <= 15'd0;
      frame_start <= 1'b0;
      col_sub     <= 2'd0;
      row_sub     <= 2'd0;
      row_base    <= 15'd0;
    end else begin
      h_count     <= h_next;
      v_count     <= v_next;
      hsync_r     <= hsync_next;
      vsync_r     <= vsync_next;
      bright_r    <= bright_next;
      read        <= read_next;
      // The post-reset (0,0) is not a wrap, so it never raises frame_start.
      frame_start <= h_wrap && v_wrap;

      // Row base steps by one buffer row every fourth active line; it is
      // settled well before the first read of the line.
      if (h_wrap) begin
        if (v_next == V_ACT) begin
          row_base <= 15'd0;
          row_sub  <= 2'd0;
        end else if (v_next > V_ACT) begin
          row_sub <= row_sub + 2'd1;
          if (row_sub == 2'd3)
            row_base <= row_base + COLS;
        end
      end

      // Column address steps once per four reads; addr holds otherwise.
      if (read_next) begin
        if (first_read) begin
          addr    <= row_base;
          col_sub <= 2'd1;
        end else begin
          col_sub <= col_sub + 2'd1;
          if (col_sub == 2'd0)
            addr <= addr + 15'd1;
        end
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_d, vsync_d, bright_d;

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      hsync_d  <= 1'b1;
      vsync_d  <= 1'b1;
      bright_d <= 1'b0;
    end else begin
      hsync_d  <= hsync_r;
      vsync_d  <= vsync_r;
      bright_d <= bright_r;
    end
  end

  assign hsync  = hsync_d;
  assign vsync  = vsync_d;
  assign bright = bright_d;
`else
  assign hsync  = hsync_r;
  assign vsync  = vsync_r;
  assign bright = bright_r;
`endif

endmodule
